ctrl_exec_pipe: RTL and testbench
=================================

# ctrl_exec_pipe

Parametrised, two-stage pipelined control-transfer execution unit for the FabScalar control lane. It resolves jumps and conditional branches, and registers the results through an issue/compute pipeline with stall and flush. On a misprediction it emits a single-cycle redirect and squashes younger control ops until the front end acknowledges with a flush. It also keeps saturating statistics counters for branches and mispredicts.

## Interface
Parameters:
- DATA_W, 32, operand width
- PC_W, 32, PC width; must be ≥ TGT_W+2 and ≥ IMM_W+2
- IMM_W, 16, branch immediate width
- TGT_W, 26, direct-jump target index width
- TAG_W, 6, branch tag width
- CNT_W, 16, statistics counter width
- CHECK_TGT, 1, 1 = a taken branch with a wrong predicted target counts as a mispredict

Ports:
- clk, in, 1, clock
- reset, in, 1, reset; asynchronous and active-high
- valid_i, in, 1, an op is presented this cycle
- stall_i, in, 1, freeze both stages
- flush_i, in, 1, front-end flush acknowledge; squashes the pipe
- cnt_clr_i, in, 1, clear the statistics counters
- opcode_i, in, `SIZE_OPCODE_I, uses codebase opcode macros (`JUMP … `BC1T)
- data1_i / data2_i, in, DATA_W, source operands
- immd_i, in, IMM_W, branch offset in words
- pc_i, in, PC_W, instruction PC
- predictedTarget_i, in, PC_W, predicted target; its low TGT_W bits are the jump index for JUMP/JAL
- predictedDir_i, in, 1, predicted direction
- tag_i, in, TAG_W, branch tag
- valid_o, out, 1, result valid
- tag_o, out, TAG_W, tag of the result
- result_o, out, PC_W, link value
- nextPC_o, out, PC_W, resolved next PC
- direction_o, out, 1, resolved direction
- flags_o, out, `EXECUTION_FLAGS (8), result flags
- redirect_o, out, 1, one-cycle mispredict pulse
- redirectPC_o, out, PC_W, correct fetch PC
- redirectTag_o, out, TAG_W, tag of the mispredicting op
- busy_o, out, 1, FSM is in HOLD
- branchCnt_o, out, CNT_W, count of resolved conditional branches
- mispredCnt_o, out, CNT_W, count of mispredicts

## Operation
Immediate and jump target formation:
- sext = sign-extended {immd_i, 2'b00} to PC_W bits.
- Taken target = pc+8+sext. Not-taken target = pc+8. All PC arithmetic is mod 2^PC_W.
- JUMP/JAL: nextPC = {pc[PC_W-1:TGT_W+2], predictedTarget_i[TGT_W-1:0], 2'b00}. Never a mispredict.
- JAL/JALR: result = pc+8.

Indirect jumps:
- JR/JALR: nextPC = data1.
- mispredict = (data1 != predictedTarget_i).

Conditional branches (sign taken from data1[DATA_W-1]):
- BEQ: d1==d2.
- BNE: d1!=d2.
- BLEZ: neg || d1==0.
- BGTZ: !neg && d1!=0.
- BLTZ: neg.
- BGEZ: !neg.
- mispredict = (dir != predictedDir_i) || (CHECK_TGT && dir && nextPC != predictedTarget_i).

Other opcodes:
- BC1F/BC1T and unknown opcodes: all outputs 0 except flags bit7 = 1.

Flags:
- bit7 = valid
- bit5 = conditional branch
- bit4 = link write (JAL/JALR)
- bit2 = control-transfer executed
- bit0 = mispredict
- All other bits are 0.

Pipeline:
- Stage A registers the inputs when valid_i && !stall_i.
- Stage B registers the computed result from stage A.

FSM (IDLE, HOLD):
- IDLE → HOLD when stage B loads a mispredicting op. In that cycle redirect_o=1 for exactly one cycle, redirectPC_o=nextPC, redirectTag_o=tag.
- In HOLD, every op reaching stage B is squashed: valid_o=0 and it is not counted.
- HOLD → IDLE on flush_i.

Flush:
- flush_i clears both stage valids in any state.
- flush_i and valid_i in the same cycle: flush wins and the input is dropped.
- flush_i in IDLE is legal: the pipe is cleared and the FSM stays in IDLE.

Counters:
- Increment on each stage-B load: branchCnt for conditional branches, mispredCnt for mispredicts.
- Both saturate at all-ones.
- cnt_clr_i has priority over increment.
- flush_i does not clear the counters.

## Timing
- Latency: an op accepted at cycle N appears on valid_o at N+2 when there are no stalls.
- Throughput: one op per cycle.
- stall_i: holds both stages and all data outputs unchanged. valid_o stays asserted. redirect_o is not re-asserted. Counters do not increment.
- Reset: asynchronous. All outputs and counters go to 0, FSM goes to IDLE. Reset asserted mid-operation discards all in-flight ops.
- redirect_o is coincident with valid_o of the mispredicting op. busy_o rises in the following cycle.
- flush_i at cycle M: valid_o=0 at M+1. The first new op can appear at M+3.

## Test plan
- BEQ, d1=d2=5, pc=0x100, immd=0x0004, predictedDir_i=1, predictedTarget_i=0x118 → at N+2: nextPC=0x118, direction=1, flags=0xA4, redirect_o=0, branchCnt=1.
- BLEZ, d1=0, predictedDir_i=0 → direction=1, flags bit0=1, redirect_o pulse with redirectPC=pc+8+sext. Three following ops yield valid_o=0. flush_i → busy_o=0 and the next op completes normally.
- JAL, pc=0x4000_0010, target index 0x10 → result=0x4000_0018, nextPC=0x4000_0040, flags=0x94.
- JR, d1=0x200, predictedTarget_i=0x204 → mispredict, redirectPC=0x200. Repeat with stall_i high for 3 cycles in the redirect cycle → outputs held, redirect_o asserted once only.
- Immediate 0xFFFF with pc=0x0000_0004, taken → nextPC = 0x0000_0008 (negative offset, sign extension). pc=0xFFFF_FFF8 not-taken → nextPC=0x0000_0000 (wrap-around).
- Counter saturation with CNT_W=4: 20 mispredicting branches with a flush between each → both counters hold at 15. cnt_clr_i together with an increment → counter reads 0. Async reset mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/ctrl_exec_pipe_if.sv
// ctrl_exec_pipe_if
// Bundles the issue-side inputs and result-side outputs of ctrl_exec_pipe.
//   master : drives the op inputs (valid/stall/flush/cnt_clr/opcode/operands/
//            pc/prediction/tag) and observes the results.
//   slave  : the execution unit; consumes the op inputs and drives valid_o,
//            tag_o, result_o, nextPC_o, direction_o, flags_o, the redirect
//            group, busy_o and the two statistics counters.
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 8
`endif

interface ctrl_exec_pipe_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 6,
  parameter int CNT_W  = 16
);
  logic                         valid_i;
  logic                         stall_i;
  logic                         flush_i;
  logic                         cnt_clr_i;
  logic [`SIZE_OPCODE_I-1:0]    opcode_i;
  logic [DATA_W-1:0]            data1_i;
  logic [DATA_W-1:0]            data2_i;
  logic [IMM_W-1:0]             immd_i;
  logic [PC_W-1:0]              pc_i;
  logic [PC_W-1:0]              predictedTarget_i;
  logic                         predictedDir_i;
  logic [TAG_W-1:0]             tag_i;

  logic                         valid_o;
  logic [TAG_W-1:0]             tag_o;
  logic [PC_W-1:0]              result_o;
  logic [PC_W-1:0]              nextPC_o;
  logic                         direction_o;
  logic [`EXECUTION_FLAGS-1:0]  flags_o;
  logic                         redirect_o;
  logic [PC_W-1:0]              redirectPC_o;
  logic [TAG_W-1:0]             redirectTag_o;
  logic                         busy_o;
  logic [CNT_W-1:0]             branchCnt_o;
  logic [CNT_W-1:0]             mispredCnt_o;

  modport master (
    output valid_i, stall_i, flush_i, cnt_clr_i, opcode_i, data1_i, data2_i,
           immd_i, pc_i, predictedTarget_i, predictedDir_i, tag_i,
    input  valid_o, tag_o, result_o, nextPC_o, direction_o, flags_o,
           redirect_o, redirectPC_o, redirectTag_o, busy_o,
           branchCnt_o, mispredCnt_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, cnt_clr_i, opcode_i, data1_i, data2_i,
           immd_i, pc_i, predictedTarget_i, predictedDir_i, tag_i,
    output valid_o, tag_o, result_o, nextPC_o, direction_o, flags_o,
           redirect_o, redirectPC_o, redirectTag_o, busy_o,
           branchCnt_o, mispredCnt_o
  );
endinterface

// File: rtl/ctrl_exec_pipe.sv
// ctrl_exec_pipe
// Two-stage control-transfer execution unit: resolves direct/indirect jumps
// and conditional branches, reports mispredicts with a one-cycle redirect,
// squashes younger ops until the front end flushes, and keeps saturating
// branch / mispredict counters.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : ctrl_exec_pipe_if.slave (op inputs, results, redirect, counters)
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 8
`endif
`ifndef JUMP
`define JUMP 8'h01
`define JAL  8'h02
`define JR   8'h03
`define JALR 8'h04
`define BEQ  8'h05
`define BNE  8'h06
`define BLEZ 8'h07
`define BGTZ 8'h08
`define BLTZ 8'h09
`define BGEZ 8'h0a
`define BC1F 8'h0b
`define BC1T 8'h0c
`endif

module ctrl_exec_pipe #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int IMM_W     = 16,
  parameter int TGT_W     = 26,
  parameter int TAG_W     = 6,
  parameter int CNT_W     = 16,
  parameter bit CHECK_TGT = 1'b1
) (
  input logic             clk,
  input logic             reset,
  ctrl_exec_pipe_if.slave bus
);

  localparam int OPC_W = `SIZE_OPCODE_I;
  localparam int FLG_W = `EXECUTION_FLAGS;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------- stage A
  logic              a_valid;
  logic [OPC_W-1:0]  a_opcode;
  logic [DATA_W-1:0] a_data1;
  logic [DATA_W-1:0] a_data2;
  logic [IMM_W-1:0]  a_immd;
  logic [PC_W-1:0]   a_pc;
  logic [PC_W-1:0]   a_ptarget;
  logic              a_pdir;
  logic [TAG_W-1:0]  a_tag;

  logic take_in;
  assign take_in = bus.valid_i && !bus.stall_i && !bus.flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid   <= 1'b0;
      a_opcode  <= '0;
      a_data1   <= '0;
      a_data2   <= '0;
      a_immd    <= '0;
      a_pc      <= '0;
      a_ptarget <= '0;
      a_pdir    <= 1'b0;
      a_tag     <= '0;
    end else begin
      if (bus.flush_i)
        a_valid <= 1'b0;
      else if (!bus.stall_i)
        a_valid <= bus.valid_i;

      if (take_in) begin
        a_opcode  <= bus.opcode_i;
        a_data1   <= bus.data1_i;
        a_data2   <= bus.data2_i;
        a_immd    <= bus.immd_i;
        a_pc      <= bus.pc_i;
        a_ptarget <= bus.predictedTarget_i;
        a_pdir    <= bus.predictedDir_i;
        a_tag     <= bus.tag_i;
      end
    end
  end

  // ------------------------------------------------------- target formation
  logic signed [IMM_W+1:0] off_bytes;
  logic [PC_W-1:0]         sext;
  logic [PC_W-1:0]         pc_plus8;
  logic [PC_W-1:0]         taken_pc;
  logic [PC_W-1:0]         jmask;
  logic [PC_W-1:0]         jump_pc;
  logic [PC_W-1:0]         d1_pc;

  assign off_bytes = {a_immd, 2'b00};
  assign sext      = PC_W'(off_bytes);
  assign pc_plus8  = a_pc + PC_W'(8);
  assign taken_pc  = pc_plus8 + sext;
  // Direct jumps keep the upper PC bits and splice in the word index.
  assign jmask     = PC_W'({(TGT_W+2){1'b1}});
  assign jump_pc   = (a_pc & ~jmask) | PC_W'({a_ptarget[TGT_W-1:0], 2'b00});
  assign d1_pc     = PC_W'(a_data1);

  // ------------------------------------------------------ branch conditions
  logic d1_neg, d1_zero, d1_eq_d2, cond_taken;

  assign d1_neg   = a_data1[DATA_W-1];
  assign d1_zero  = (a_data1 == '0);
  assign d1_eq_d2 = (a_data1 == a_data2);

  always_comb begin
    cond_taken = 1'b0;
    case (a_opcode)
      `BEQ:    cond_taken = d1_eq_d2;
      `BNE:    cond_taken = !d1_eq_d2;
      `BLEZ:   cond_taken = d1_neg || d1_zero;
      `BGTZ:   cond_taken = !d1_neg && !d1_zero;
      `BLTZ:   cond_taken = d1_neg;
      `BGEZ:   cond_taken = !d1_neg;
      default: cond_taken = 1'b0;
    endcase
  end

  // ---------------------------------------------------------- op resolution
  logic             c_dir, c_mispred, c_cond, c_link, c_ctrl;
  logic [PC_W-1:0]  c_next, c_result;
  logic [TAG_W-1:0] c_tag;
  logic [FLG_W-1:0] c_flags;

  always_comb begin
    c_dir     = 1'b0;
    c_mispred = 1'b0;
    c_cond    = 1'b0;
    c_link    = 1'b0;
    c_ctrl    = 1'b0;
    c_next    = '0;
    c_result  = '0;
    case (a_opcode)
      `JUMP, `JAL: begin
        c_ctrl   = 1'b1;
        c_dir    = 1'b1;
        c_next   = jump_pc;
        c_link   = (a_opcode == `JAL);
        c_result = c_link ? pc_plus8 : '0;
      end
      `JR, `JALR: begin
        c_ctrl    = 1'b1;
        c_dir     = 1'b1;
        c_next    = d1_pc;
        c_mispred = (d1_pc != a_ptarget);
        c_link    = (a_opcode == `JALR);
        c_result  = c_link ? pc_plus8 : '0;
      end
      `BEQ, `BNE, `BLEZ, `BGTZ, `BLTZ, `BGEZ: begin
        c_ctrl    = 1'b1;
        c_cond    = 1'b1;
        c_dir     = cond_taken;
        c_next    = cond_taken ? taken_pc : pc_plus8;
        c_mispred = (cond_taken != a_pdir) ||
                    (CHECK_TGT && cond_taken && (c_next != a_ptarget));
      end
      default: ;  // BC1F/BC1T and unknown ops resolve to an all-zero result
    endcase

    c_tag      = c_ctrl ? a_tag : '0;
    c_flags    = '0;
    c_flags[7] = 1'b1;
    c_flags[5] = c_cond;
    c_flags[4] = c_link;
    c_flags[2] = c_ctrl;
    c_flags[0] = c_mispred;
  end

  // -------------------------------------------------------------- FSM
  logic redirect_q;
  logic squash, b_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // HOLD is entered on the cycle after the redirect pulse so busy_o trails
  // redirect_o; the pending pulse itself already squashes the next load.
  always_comb begin
    state_next = state;
    squash     = (state == HOLD) || redirect_q;
    b_take     = a_valid && !squash && !bus.stall_i && !bus.flush_i;
    if (bus.flush_i)
      state_next = IDLE;
    else if (redirect_q)
      state_next = HOLD;
  end

  // ---------------------------------------------------------------- stage B
  logic             b_valid;
  logic [TAG_W-1:0] b_tag;
  logic [PC_W-1:0]  b_result;
  logic [PC_W-1:0]  b_next;
  logic             b_dir;
  logic [FLG_W-1:0] b_flags;
  logic [PC_W-1:0]  r_pc;
  logic [TAG_W-1:0] r_tag;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid    <= 1'b0;
      b_tag      <= '0;
      b_result   <= '0;
      b_next     <= '0;
      b_dir      <= 1'b0;
      b_flags    <= '0;
      redirect_q <= 1'b0;
      r_pc       <= '0;
      r_tag      <= '0;
      br_cnt     <= '0;
      mp_cnt     <= '0;
    end else begin
      // The redirect is a pulse: it drops after one cycle even under stall.
      redirect_q <= 1'b0;

      if (bus.flush_i) begin
        b_valid <= 1'b0;
      end else if (!bus.stall_i) begin
        b_valid  <= b_take;
        b_tag    <= b_take ? c_tag    : '0;
        b_result <= b_take ? c_result : '0;
        b_next   <= b_take ? c_next   : '0;
        b_dir    <= b_take ? c_dir    : 1'b0;
        b_flags  <= b_take ? c_flags  : '0;
        if (b_take && c_mispred) begin
          redirect_q <= 1'b1;
          r_pc       <= c_next;
          r_tag      <= a_tag;
        end
      end

      if (bus.cnt_clr_i) begin
        br_cnt <= '0;
        mp_cnt <= '0;
      end else if (b_take) begin
        if (c_cond && (br_cnt != '1))
          br_cnt <= br_cnt + CNT_W'(1);
        if (c_mispred && (mp_cnt != '1))
          mp_cnt <= mp_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.valid_o       = b_valid;
  assign bus.tag_o         = b_tag;
  assign bus.result_o      = b_result;
  assign bus.nextPC_o      = b_next;
  assign bus.direction_o   = b_dir;
  assign bus.flags_o       = b_flags;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirectPC_o  = r_pc;
  assign bus.redirectTag_o = r_tag;
  assign bus.busy_o        = (state == HOLD);
  assign bus.branchCnt_o   = br_cnt;
  assign bus.mispredCnt_o  = mp_cnt;

endmodule

// File: tb/tb_ctrl_exec_pipe.sv
// tb_ctrl_exec_pipe
// Randomised plus directed bench for ctrl_exec_pipe with a transaction-level
// reference model (op resolution by plain arithmetic, two-slot pipe).
`timescale 1ns/1ps
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 8
`endif
`ifndef JUMP
`define JUMP 8'h01
`define JAL  8'h02
`define JR   8'h03
`define JALR 8'h04
`define BEQ  8'h05
`define BNE  8'h06
`define BLEZ 8'h07
`define BGTZ 8'h08
`define BLTZ 8'h09
`define BGEZ 8'h0a
`define BC1F 8'h0b
`define BC1T 8'h0c
`endif

module tb_ctrl_exec_pipe;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int IMM_W  = 16;
  localparam int TGT_W  = 26;
  localparam int TAG_W  = 6;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_exec_pipe_if #(.DATA_W(DATA_W), .PC_W(PC_W), .IMM_W(IMM_W),
                      .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  ctrl_exec_pipe #(.DATA_W(DATA_W), .PC_W(PC_W), .IMM_W(IMM_W), .TGT_W(TGT_W),
                   .TAG_W(TAG_W), .CNT_W(CNT_W), .CHECK_TGT(1'b1))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [7:0]  opc;
    logic [31:0] d1, d2;
    logic [15:0] imm;
    logic [31:0] pc, pt;
    logic        pdir;
    logic [5:0]  tag;
  } op_t;

  typedef struct {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] result, nextpc;
    logic        dir;
    logic [7:0]  flags;
    logic        mis, cond;
  } res_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  op_t         ma_op;
  logic        ma_valid;
  res_t        mb;
  logic        m_busy, m_redir;
  logic [31:0] m_rpc;
  logic [5:0]  m_rtag;
  int          m_bcnt, m_mcnt;

  function automatic op_t mk(logic [7:0] opc, logic [31:0] d1, logic [31:0] d2,
                             logic [15:0] imm, logic [31:0] pc, logic [31:0] pt,
                             logic pdir, logic [5:0] tag);
    op_t o;
    o.opc = opc; o.d1 = d1; o.d2 = d2; o.imm = imm;
    o.pc = pc; o.pt = pt; o.pdir = pdir; o.tag = tag;
    return o;
  endfunction

  // What the op must produce, straight from the architectural rules.
  function automatic res_t resolve(op_t o);
    res_t        r;
    logic [31:0] fall, taken;
    int          off;
    logic        neg, ctrl;
    r = '{default: '0};
    fall  = o.pc + 32'd8;
    off   = int'($signed(o.imm)) * 4;
    taken = fall + 32'(off);
    neg   = o.d1[31];
    ctrl  = 1'b1;
    r.valid = 1'b1;
    case (o.opc)
      `JUMP, `JAL: begin
        r.nextpc = {o.pc[31:28], o.pt[25:0], 2'b00};
        r.dir = 1'b1;
        if (o.opc == `JAL) r.result = fall;
      end
      `JR, `JALR: begin
        r.nextpc = o.d1;
        r.dir = 1'b1;
        r.mis = (o.d1 != o.pt);
        if (o.opc == `JALR) r.result = fall;
      end
      `BEQ, `BNE, `BLEZ, `BGTZ, `BLTZ, `BGEZ: begin
        r.cond = 1'b1;
        case (o.opc)
          `BEQ:    r.dir = (o.d1 == o.d2);
          `BNE:    r.dir = (o.d1 != o.d2);
          `BLEZ:   r.dir = neg || (o.d1 == 0);
          `BGTZ:   r.dir = !neg && (o.d1 != 0);
          `BLTZ:   r.dir = neg;
          default: r.dir = !neg;
        endcase
        r.nextpc = r.dir ? taken : fall;
        r.mis = (r.dir != o.pdir) || (r.dir && r.nextpc != o.pt);
      end
      default: ctrl = 1'b0;
    endcase
    r.tag   = ctrl ? o.tag : 6'd0;
    r.flags = 8'h80 | (r.cond ? 8'h20 : 8'h00) |
              ((o.opc == `JAL || o.opc == `JALR) ? 8'h10 : 8'h00) |
              (ctrl ? 8'h04 : 8'h00) | (r.mis ? 8'h01 : 8'h00);
    return r;
  endfunction

  task automatic model_reset();
    ma_valid = 1'b0;
    ma_op    = mk(8'h00, 0, 0, 0, 0, 0, 1'b0, 0);
    mb       = '{default: '0};
    m_busy   = 1'b0;
    m_redir  = 1'b0;
    m_rpc    = '0;
    m_rtag   = '0;
    m_bcnt   = 0;
    m_mcnt   = 0;
  endtask

  task automatic model_step(logic v, logic st, logic fl, logic clr, op_t o);
    logic squash, nbusy, nredir;
    res_t r;
    squash = m_busy || m_redir;
    nbusy  = fl ? 1'b0 : (m_redir ? 1'b1 : m_busy);
    nredir = 1'b0;
    if (fl) begin
      ma_valid = 1'b0;
      mb.valid = 1'b0;
    end else if (!st) begin
      if (ma_valid && !squash) begin
        r  = resolve(ma_op);
        mb = r;
        if (!clr) begin
          if (r.cond && m_bcnt < CMAX) m_bcnt++;
          if (r.mis  && m_mcnt < CMAX) m_mcnt++;
        end
        if (r.mis) begin
          nredir = 1'b1;
          m_rpc  = r.nextpc;
          m_rtag = ma_op.tag;
        end
      end else begin
        mb.valid = 1'b0;
      end
      ma_valid = v;
      ma_op    = o;
    end
    if (clr) begin
      m_bcnt = 0;
      m_mcnt = 0;
    end
    m_redir = nredir;
    m_busy  = nbusy;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("valid_o", 64'(bus.valid_o), 64'(mb.valid));
    chk("busy_o", 64'(bus.busy_o), 64'(m_busy));
    chk("redirect_o", 64'(bus.redirect_o), 64'(m_redir));
    chk("branchCnt_o", 64'(bus.branchCnt_o), 64'(m_bcnt));
    chk("mispredCnt_o", 64'(bus.mispredCnt_o), 64'(m_mcnt));
    if (mb.valid) begin
      chk("tag_o", 64'(bus.tag_o), 64'(mb.tag));
      chk("result_o", 64'(bus.result_o), 64'(mb.result));
      chk("nextPC_o", 64'(bus.nextPC_o), 64'(mb.nextpc));
      chk("direction_o", 64'(bus.direction_o), 64'(mb.dir));
      chk("flags_o", 64'(bus.flags_o), 64'(mb.flags));
    end
    if (m_redir) begin
      chk("redirectPC_o", 64'(bus.redirectPC_o), 64'(m_rpc));
      chk("redirectTag_o", 64'(bus.redirectTag_o), 64'(m_rtag));
    end
  endtask

  task automatic cyc(logic v, logic st, logic fl, logic clr, op_t o);
    bus.valid_i           = v;
    bus.stall_i           = st;
    bus.flush_i           = fl;
    bus.cnt_clr_i         = clr;
    bus.opcode_i          = o.opc;
    bus.data1_i           = o.d1;
    bus.data2_i           = o.d2;
    bus.immd_i            = o.imm;
    bus.pc_i              = o.pc;
    bus.predictedTarget_i = o.pt;
    bus.predictedDir_i    = o.pdir;
    bus.tag_i             = o.tag;
    @(posedge clk);
    #1;
    model_step(v, st, fl, clr, o);
    compare_all();
  endtask

  task automatic chk_all_zero(string name);
    chk({name, "_valid"}, 64'(bus.valid_o), 64'd0);
    chk({name, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({name, "_redirect"}, 64'(bus.redirect_o), 64'd0);
    chk({name, "_nextPC"}, 64'(bus.nextPC_o), 64'd0);
    chk({name, "_flags"}, 64'(bus.flags_o), 64'd0);
    chk({name, "_bcnt"}, 64'(bus.branchCnt_o), 64'd0);
    chk({name, "_mcnt"}, 64'(bus.mispredCnt_o), 64'd0);
  endtask

  function automatic op_t rnd_op();
    op_t         o;
    int          k;
    logic [31:0] pool [5];
    res_t        r;
    k = $urandom_range(0, 14);
    if (k < 12)       o.opc = 8'(k + 1);
    else if (k == 12) o.opc = 8'h00;
    else if (k == 13) o.opc = 8'h2f;
    else              o.opc = 8'h0d;
    pool[0] = 32'd0; pool[1] = 32'd5; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = $urandom;
    o.d1   = pool[$urandom_range(0, 4)];
    o.d2   = pool[$urandom_range(0, 4)];
    o.imm  = 16'($urandom);
    o.pc   = $urandom & 32'hFFFF_FFFC;
    o.pt   = $urandom;
    o.tag  = 6'($urandom);
    r      = resolve(o);
    o.pdir = ($urandom_range(0, 9) < 7) ? r.dir : 1'($urandom);
    if ($urandom_range(0, 1) == 1) o.pt = r.nextpc;
    return o;
  endfunction

  op_t idle, t;
  int  k;

  initial begin
    idle = mk(8'h00, 0, 0, 0, 0, 0, 1'b0, 0);
    reset = 1'b1;
    bus.valid_i = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    bus.cnt_clr_i = 1'b0; bus.opcode_i = '0; bus.data1_i = '0;
    bus.data2_i = '0; bus.immd_i = '0; bus.pc_i = '0;
    bus.predictedTarget_i = '0; bus.predictedDir_i = 1'b0; bus.tag_i = '0;
    model_reset();
    #12;
    chk_all_zero("reset");
    reset = 1'b0;

    // BEQ taken, correctly predicted
    cyc(1, 0, 0, 0, mk(`BEQ, 5, 5, 16'h0004, 32'h100, 32'h118, 1'b1, 6'd1));
    cyc(0, 0, 0, 0, idle);
    chk("beq_nextPC", 64'(bus.nextPC_o), 64'h118);
    chk("beq_dir", 64'(bus.direction_o), 64'd1);
    chk("beq_flags", 64'(bus.flags_o), 64'hA4);
    chk("beq_redirect", 64'(bus.redirect_o), 64'd0);
    chk("beq_bcnt", 64'(bus.branchCnt_o), 64'd1);

    // JAL
    cyc(1, 0, 0, 0, mk(`JAL, 0, 0, 0, 32'h4000_0010, 32'h10, 1'b1, 6'd2));
    cyc(0, 0, 0, 0, idle);
    chk("jal_result", 64'(bus.result_o), 64'h4000_0018);
    chk("jal_nextPC", 64'(bus.nextPC_o), 64'h4000_0040);
    chk("jal_flags", 64'(bus.flags_o), 64'h94);

    // negative offset, then not-taken wrap-around, back to back
    cyc(1, 0, 0, 0, mk(`BGEZ, 0, 0, 16'hFFFF, 32'h4, 32'h8, 1'b1, 6'd3));
    cyc(1, 0, 0, 0, mk(`BLTZ, 1, 0, 16'h0010, 32'hFFFF_FFF8, 32'h0, 1'b0, 6'd4));
    chk("neg_off_nextPC", 64'(bus.nextPC_o), 64'h8);
    cyc(0, 0, 0, 0, idle);
    chk("wrap_nextPC", 64'(bus.nextPC_o), 64'h0);
    chk("wrap_valid", 64'(bus.valid_o), 64'd1);

    // BLEZ mispredict, squash window, flush
    cyc(1, 0, 0, 0, mk(`BLEZ, 0, 0, 16'h0002, 32'h300, 32'h0, 1'b0, 6'd9));
    cyc(1, 0, 0, 0, mk(`BEQ, 1, 1, 0, 32'h500, 32'h508, 1'b1, 6'd10));
    chk("blez_redirect", 64'(bus.redirect_o), 64'd1);
    chk("blez_redirectPC", 64'(bus.redirectPC_o), 64'h310);
    chk("blez_flags", 64'(bus.flags_o), 64'hA5);
    chk("blez_busy_lag", 64'(bus.busy_o), 64'd0);
    cyc(1, 0, 0, 0, mk(`BNE, 1, 2, 0, 32'h600, 32'h608, 1'b1, 6'd11));
    cyc(1, 0, 0, 0, mk(`JR, 32'h40, 0, 0, 32'h700, 32'h40, 1'b1, 6'd12));
    cyc(0, 0, 0, 0, idle);
    chk("hold_valid", 64'(bus.valid_o), 64'd0);
    chk("hold_busy", 64'(bus.busy_o), 64'd1);
    cyc(1, 0, 1, 0, mk(`BEQ, 1, 1, 0, 32'h800, 32'h808, 1'b1, 6'd13));
    chk("flush_busy", 64'(bus.busy_o), 64'd0);
    cyc(0, 0, 0, 0, idle);
    cyc(1, 0, 0, 0, mk(`BEQ, 7, 7, 0, 32'h900, 32'h908, 1'b1, 6'd14));
    cyc(0, 0, 0, 0, idle);
    chk("after_flush_valid", 64'(bus.valid_o), 64'd1);

    // JR mispredict, then again with stall across the redirect cycle
    cyc(1, 0, 0, 0, mk(`JR, 32'h200, 0, 0, 32'hA00, 32'h204, 1'b1, 6'h11));
    cyc(0, 0, 0, 0, idle);
    chk("jr_redirectPC", 64'(bus.redirectPC_o), 64'h200);
    chk("jr_flags", 64'(bus.flags_o), 64'h85);
    cyc(0, 0, 1, 0, idle);
    cyc(1, 0, 0, 0, mk(`JR, 32'h200, 0, 0, 32'hA00, 32'h204, 1'b1, 6'h12));
    cyc(0, 0, 0, 0, idle);
    chk("jr2_redirect", 64'(bus.redirect_o), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, idle);
    chk("stall_redirect_once", 64'(bus.redirect_o), 64'd0);
    chk("stall_valid_held", 64'(bus.valid_o), 64'd1);
    chk("stall_nextPC_held", 64'(bus.nextPC_o), 64'h200);
    cyc(0, 0, 1, 0, idle);

    // counter saturation
    cyc(0, 0, 0, 1, idle);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, mk(`BEQ, 3, 3, 0, 32'h1000, 32'h1008, 1'b0, 6'(i)));
      cyc(0, 0, 0, 0, idle);
      cyc(0, 0, 0, 0, idle);
      cyc(0, 0, 1, 0, idle);
    end
    chk("sat_bcnt", 64'(bus.branchCnt_o), 64'd15);
    chk("sat_mcnt", 64'(bus.mispredCnt_o), 64'd15);
    cyc(1, 0, 0, 0, mk(`BEQ, 3, 3, 0, 32'h1000, 32'h1008, 1'b1, 6'd5));
    cyc(0, 0, 0, 1, idle);
    chk("clr_prio_bcnt", 64'(bus.branchCnt_o), 64'd0);
    chk("clr_prio_valid", 64'(bus.valid_o), 64'd1);

    // randomised traffic with an asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        #1 reset = 1'b0;
      end
      t = rnd_op();
      k = m_busy ? 4 : 60;
      cyc(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 9) < 2),
          logic'($urandom_range(0, k - 1) == 0), logic'($urandom_range(0, 99) == 0), t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
